instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Inverse of the control decoder: accepts symbolic operations (op select plus register and immediate fields) over a valid/ready handshake and encodes each into a 32-bit MIPS instruction word.
- Writes the encoded words sequentially into instruction memory.
- Used by the bench and boot path to load programs into the mips4 core before releasing it from reset.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- DEPTH, 256, max words loaded per session; must be ≤ 2^ADDR_W.
- BASE_ADDR, 0, first word address written after start.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high; clears all state
- start  input  1  one-cycle pulse; begins a load session (ignored while LOAD)
- in_valid  input  1  request fields valid
- in_ready  output  1  encoder can accept a request this cycle
- in_op  input  4  op select: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 MULT, 7 LW, 8 SW, 9 ADDI, 10 BEQ, 11 BNE, 12 J; 13-15 invalid
- in_rs, in_rt, in_rd  input  5 each  register fields
- in_imm  input  26  imm16 in [15:0] for I-type; target26 for J
- in_last  input  1  marks final instruction of the program
- imem_we  output  1  instruction-memory write strobe
- imem_addr  output  ADDR_W  write word address
- imem_wdata  output  32  encoded instruction
- count  output  ADDR_W+1  words written this session
- busy  output  1  high in LOAD
- done  output  1  high in DONE
- err  output  1  sticky invalid-op flag, cleared by start or reset

Behaviour:
- Reset values:
  - in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, count=0, busy=0, done=0, err=0.
  - State IDLE.
- FSM: IDLE, LOAD, DONE.
  - IDLE/DONE + start → LOAD: addr←BASE_ADDR, count←0, err←0, done←0.
  - LOAD → DONE when an accepted request has in_last=1, or count reaches DEPTH after a write.
  - start during LOAD is ignored.
- in_ready = (state==LOAD) && (count < DEPTH). Combinational from state and count only; never from in_valid.
- Transfer occurs when in_valid && in_ready at a rising edge.
- Latency: registered.
  - imem_we pulses exactly one cycle, the cycle after acceptance.
  - imem_addr/imem_wdata are stable while imem_we=1.
  - addr and count increment with each write.
- Back-to-back acceptance every cycle is permitted (throughput 1/cycle).
- Encoding:
  - R-type (ops 0-6): {6'd0, rs, rt, rd, 5'd0, funct}, with funct ADD 32, SUB 34, AND 36, OR 37, XOR 38, NOR 39, MULT 24.
  - I-type: {opcode, rs, rt, imm[15:0]}, with opcode LW 35, SW 43, ADDI 8, BEQ 4, BNE 5.
  - J: {6'd2, imm[25:0]}.
  - Unused input bits are ignored.
- Invalid op (13-15):
  - Still accepted and consumes the handshake.
  - No write; addr/count unchanged; err←1 (sticky).
  - If in_last=1, still transitions to DONE.
- Full: when count==DEPTH, in_ready drops and the FSM enters DONE. Further in_valid is left unaccepted.
- Address wrap: imem_addr wraps modulo 2^ADDR_W. Count does not wrap; it saturates at DEPTH by construction.
- Reset mid-LOAD:
  - Any pending write is dropped (imem_we=0 next cycle).
  - All outputs return to reset values; state IDLE.

Decomposition:
- Shared package mips_pkg:
  - op-select enum values 0-12.
  - Opcode constants 0, 2, 4, 5, 8, 35, 43.
  - Funct constants 24, 32, 34, 36, 37, 38, 39.
  - The same constants are used by the Control decoder, keeping the decode and encode directions consistent.
- One sub-module: instr_encode, purely combinational. It maps op/rs/rt/rd/imm to {word, valid}. The top holds the FSM, counters and output registers.

Test Plan:
- start; ADD rs=1 rt=2 rd=3 → one cycle later imem_we=1, addr=0, wdata=0x00221820; count=1.
- Back-to-back stream of 3 requests:
  - SUB 1,2,3 → 0x00221822
  - LW rs=16 rt=8 imm=4 → 0x8E080004
  - BEQ rs=1 rt=2 imm=0xFFFF → 0x1022FFFF
  - Writes go to addrs 0,1,2 on consecutive cycles.
- J imm=0x100 with in_last=1 → wdata=0x08000100; next cycle done=1, busy=0, in_ready=0. A new start returns to LOAD with addr=0 and count=0.
- op=14 between two valid ADDs → err=1; only 2 writes at addrs 0,1; err persists until next start.
- DEPTH=4 with in_valid held high and no in_last → exactly 4 writes, then in_ready=0 and done=1.
- reset asserted the cycle after an acceptance → no imem_we; next cycle all outputs at reset values, state IDLE.

Source files
------------

// File: rtl/instr_encoder_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder_loader_pkg
// Description : Op-select codes, MIPS opcode/funct constants and field
//               packing helpers. The control decoder uses the same constants,
//               which keeps the decode and encode directions consistent.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_encoder_loader_pkg;

  // Symbolic operation select presented on in_op (13-15 are invalid)
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOR  = 4'd5,
    OP_MULT = 4'd6,
    OP_LW   = 4'd7,
    OP_SW   = 4'd8,
    OP_ADDI = 4'd9,
    OP_BEQ  = 4'd10,
    OP_BNE  = 4'd11,
    OP_J    = 4'd12
  } op_e;

  // Primary opcodes
  localparam logic [5:0] OPC_RTYPE = 6'd0;
  localparam logic [5:0] OPC_J     = 6'd2;
  localparam logic [5:0] OPC_BEQ   = 6'd4;
  localparam logic [5:0] OPC_BNE   = 6'd5;
  localparam logic [5:0] OPC_ADDI  = 6'd8;
  localparam logic [5:0] OPC_LW    = 6'd35;
  localparam logic [5:0] OPC_SW    = 6'd43;

  // R-type function codes
  localparam logic [5:0] FN_MULT = 6'd24;
  localparam logic [5:0] FN_ADD  = 6'd32;
  localparam logic [5:0] FN_SUB  = 6'd34;
  localparam logic [5:0] FN_AND  = 6'd36;
  localparam logic [5:0] FN_OR   = 6'd37;
  localparam logic [5:0] FN_XOR  = 6'd38;
  localparam logic [5:0] FN_NOR  = 6'd39;

  // R-type: {opcode 0, rs, rt, rd, shamt 0, funct}
  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    return {OPC_RTYPE, rs, rt, rd, 5'd0, funct};
  endfunction

  // I-type: {opcode, rs, rt, imm16}
  function automatic logic [31:0] enc_i(input logic [5:0] opcode, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {opcode, rs, rt, imm};
  endfunction

  // J-type: {opcode, target26}
  function automatic logic [31:0] enc_j(input logic [25:0] target);
    return {OPC_J, target};
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_encoder_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder_loader_if
// Description : Request handshake (symbolic op in) and instruction-memory
//               write bus (encoded word out) of the encoder/loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [25:0]       in_imm;
  logic              in_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  // Request producer / memory sink side
  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_last,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  // Encoder/loader side
  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_last,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/instr_encoder_loader_encode.sv
`default_nettype none
// ============================================================================
// Module      : instr_encode
// Description : Purely combinational map from symbolic op + fields to a
//               32-bit MIPS instruction word; valid=0 for unknown ops.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encode
  import instr_encoder_loader_pkg::*;
(
  input  wire logic [3:0]  op,
  input  wire logic [4:0]  rs,
  input  wire logic [4:0]  rt,
  input  wire logic [4:0]  rd,
  input  wire logic [25:0] imm,
  output logic [31:0]      word,
  output logic             valid
);

  // Select the instruction format and constant for each op
  always_comb begin
    word  = 32'd0;
    valid = 1'b1;
    case (op)
      OP_ADD:  word = enc_r(rs, rt, rd, FN_ADD);
      OP_SUB:  word = enc_r(rs, rt, rd, FN_SUB);
      OP_AND:  word = enc_r(rs, rt, rd, FN_AND);
      OP_OR:   word = enc_r(rs, rt, rd, FN_OR);
      OP_XOR:  word = enc_r(rs, rt, rd, FN_XOR);
      OP_NOR:  word = enc_r(rs, rt, rd, FN_NOR);
      OP_MULT: word = enc_r(rs, rt, rd, FN_MULT);
      OP_LW:   word = enc_i(OPC_LW,   rs, rt, imm[15:0]);
      OP_SW:   word = enc_i(OPC_SW,   rs, rt, imm[15:0]);
      OP_ADDI: word = enc_i(OPC_ADDI, rs, rt, imm[15:0]);
      OP_BEQ:  word = enc_i(OPC_BEQ,  rs, rt, imm[15:0]);
      OP_BNE:  word = enc_i(OPC_BNE,  rs, rt, imm[15:0]);
      OP_J:    word = enc_j(imm);
      default: valid = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder_loader
// Description : Accepts symbolic ops over valid/ready, encodes them and writes
//               the words to sequential instruction-memory addresses.
//               IDLE -> LOAD on start; LOAD -> DONE on last or full.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              start,
  instr_encoder_loader_if.slave  bus,
  output logic [ADDR_W:0]        count,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;      // next address to be written
  logic [ADDR_W-1:0] addr_q, addr_d;    // address presented with the strobe
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;

  logic              ready;
  logic              accept;
  logic              session_start;
  logic [31:0]       enc_word;
  logic              enc_valid;

  instr_encode u_encode (
    .op    (bus.in_op),
    .rs    (bus.in_rs),
    .rt    (bus.in_rt),
    .rd    (bus.in_rd),
    .imm   (bus.in_imm),
    .word  (enc_word),
    .valid (enc_valid)
  );

  assign accept        = bus.in_valid && ready;
  assign session_start = start && (state_q != S_LOAD);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: finish on an accepted last, or when a write fills the session
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_LOAD;
      S_LOAD: begin
        if (accept && (bus.in_last ||
                       (enc_valid && (count_q + 1'b1 == DEPTH_CNT))))
          state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs; ready depends only on state and count, never on in_valid
  always_comb begin
    busy  = (state_q == S_LOAD);
    done  = (state_q == S_DONE);
    ready = (state_q == S_LOAD) && (count_q < DEPTH_CNT);
  end

  // Datapath next values: a valid accept schedules a one-cycle write strobe
  always_comb begin
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    count_d = count_q;
    err_d   = err_q;
    if (session_start) begin
      ptr_d   = BASE;
      addr_d  = BASE;
      count_d = '0;
      err_d   = 1'b0;
    end else if (accept) begin
      if (enc_valid) begin
        we_d    = 1'b1;
        addr_d  = ptr_q;
        wdata_d = enc_word;
        ptr_d   = ptr_q + 1'b1;   // wraps modulo 2^ADDR_W
        count_d = count_q + 1'b1;
      end else begin
        err_d   = 1'b1;
      end
    end
  end

  // Datapath registers; reset drops any pending write
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= BASE;
      addr_q  <= BASE;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready   = ready;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign count          = count_q;
  assign err            = err_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder_loader
// Description : Directed self-checking bench for instr_encoder_loader; a
//               second instance with DEPTH=4 exercises the full condition.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic [8:0] count_a, count_b;
  logic       busy_a, done_a, err_a;
  logic       busy_b, done_b, err_b;

  int n_cmp = 0;
  int n_bad = 0;

  instr_encoder_loader_if #(.ADDR_W(8)) bus_a ();
  instr_encoder_loader_if #(.ADDR_W(8)) bus_b ();

  instr_encoder_loader #(.ADDR_W(8), .DEPTH(256), .BASE_ADDR(0)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .bus(bus_a),
    .count(count_a), .busy(busy_a), .done(done_a), .err(err_a)
  );

  instr_encoder_loader #(.ADDR_W(8), .DEPTH(4), .BASE_ADDR(0)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .bus(bus_b),
    .count(count_b), .busy(busy_b), .done(done_b), .err(err_b)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic valid, input logic [3:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd,
                         input logic [25:0] imm, input logic last);
    bus_a.in_valid = valid;
    bus_a.in_op    = op;
    bus_a.in_rs    = rs;
    bus_a.in_rt    = rt;
    bus_a.in_rd    = rd;
    bus_a.in_imm   = imm;
    bus_a.in_last  = last;
  endtask

  task automatic begin_session_a;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_cmp++;
    if ({bus_a.in_ready, bus_a.imem_we, busy_a, done_a, err_a} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 00000",
               {bus_a.in_ready, bus_a.imem_we, busy_a, done_a, err_a});
    end
    n_cmp++;
    if ({bus_a.imem_addr, bus_a.imem_wdata, count_a} !== 49'd0) begin
      n_bad++;
      $display("FAIL reset_regs: got addr=%0h wdata=%0h count=%0d want 0/0/0",
               bus_a.imem_addr, bus_a.imem_wdata, count_a);
    end
  endtask

  task automatic test_add;
    begin_session_a();
    n_cmp++;
    if ({busy_a, bus_a.in_ready, count_a} !== {2'b11, 9'd0}) begin
      n_bad++;
      $display("FAIL add_enter_load: got busy=%b ready=%b count=%0d want 1/1/0",
               busy_a, bus_a.in_ready, count_a);
    end
    drive_a(1'b1, 4'd0, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0);
    tick();
    drive_a(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b0);
    n_cmp++;
    if ({bus_a.imem_we, bus_a.imem_addr, bus_a.imem_wdata, count_a} !==
        {1'b1, 8'd0, 32'h00221820, 9'd1}) begin
      n_bad++;
      $display("FAIL add_write: got we=%b addr=%0h wdata=%08h count=%0d want 1/0/00221820/1",
               bus_a.imem_we, bus_a.imem_addr, bus_a.imem_wdata, count_a);
    end
    tick();
    n_cmp++;
    if (bus_a.imem_we !== 1'b0) begin
      n_bad++;
      $display("FAIL add_we_pulse: got we=%b want 0", bus_a.imem_we);
    end
  endtask

  task automatic test_back_to_back;
    begin_session_a();
    drive_a(1'b1, 4'd1, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0);
    tick();
    n_cmp++;
    if ({bus_a.imem_we, bus_a.imem_addr, bus_a.imem_wdata} !== {1'b1, 8'd0, 32'h00221822}) begin
      n_bad++;
      $display("FAIL b2b_sub: got we=%b addr=%0h wdata=%08h want 1/0/00221822",
               bus_a.imem_we, bus_a.imem_addr, bus_a.imem_wdata);
    end
    drive_a(1'b1, 4'd7, 5'd16, 5'd8, 5'd0, 26'd4, 1'b0);
    start_a = 1'b1;  // must be ignored while loading
    tick();
    start_a = 1'b0;
    n_cmp++;
    if ({bus_a.imem_we, bus_a.imem_addr, bus_a.imem_wdata} !== {1'b1, 8'd1, 32'h8E080004}) begin
      n_bad++;
      $display("FAIL b2b_lw: got we=%b addr=%0h wdata=%08h want 1/1/8E080004",
               bus_a.imem_we, bus_a.imem_addr, bus_a.imem_wdata);
    end
    drive_a(1'b1, 4'd10, 5'd1, 5'd2, 5'd0, 26'h000FFFF, 1'b0);
    tick();
    drive_a(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b0);
    n_cmp++;
    if ({bus_a.imem_we, bus_a.imem_addr, bus_a.imem_wdata, count_a} !==
        {1'b1, 8'd2, 32'h1022FFFF, 9'd3}) begin
      n_bad++;
      $display("FAIL b2b_beq: got we=%b addr=%0h wdata=%08h count=%0d want 1/2/1022FFFF/3",
               bus_a.imem_we, bus_a.imem_addr, bus_a.imem_wdata, count_a);
    end
    tick();
    n_cmp++;
    if ({bus_a.imem_we, busy_a, count_a} !== {2'b01, 9'd3}) begin
      n_bad++;
      $display("FAIL b2b_idle_gap: got we=%b busy=%b count=%0d want 0/1/3",
               bus_a.imem_we, busy_a, count_a);
    end
  endtask

  task automatic test_last;
    drive_a(1'b1, 4'd12, 5'd0, 5'd0, 5'd0, 26'h0000100, 1'b1);
    tick();
    drive_a(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b0);
    n_cmp++;
    if ({bus_a.imem_we, bus_a.imem_addr, bus_a.imem_wdata} !== {1'b1, 8'd3, 32'h08000100}) begin
      n_bad++;
      $display("FAIL last_j: got we=%b addr=%0h wdata=%08h want 1/3/08000100",
               bus_a.imem_we, bus_a.imem_addr, bus_a.imem_wdata);
    end
    n_cmp++;
    if ({done_a, busy_a, bus_a.in_ready} !== 3'b100) begin
      n_bad++;
      $display("FAIL last_done: got done/busy/ready=%b want 100",
               {done_a, busy_a, bus_a.in_ready});
    end
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n_cmp++;
    if ({busy_a, done_a, bus_a.in_ready, bus_a.imem_addr, count_a} !==
        {3'b101, 8'd0, 9'd0}) begin
      n_bad++;
      $display("FAIL last_restart: got busy=%b done=%b ready=%b addr=%0h count=%0d want 1/0/1/0/0",
               busy_a, done_a, bus_a.in_ready, bus_a.imem_addr, count_a);
    end
  endtask

  task automatic test_invalid;
    drive_a(1'b1, 4'd0, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0);
    tick();
    drive_a(1'b1, 4'd14, 5'd7, 5'd7, 5'd7, 26'h3FFFFFF, 1'b0);
    tick();
    n_cmp++;
    if ({bus_a.imem_we, err_a, count_a} !== {2'b01, 9'd1}) begin
      n_bad++;
      $display("FAIL inv_op14: got we=%b err=%b count=%0d want 0/1/1",
               bus_a.imem_we, err_a, count_a);
    end
    drive_a(1'b1, 4'd0, 5'd4, 5'd5, 5'd6, 26'd0, 1'b1);
    tick();
    drive_a(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b0);
    n_cmp++;
    if ({bus_a.imem_we, bus_a.imem_addr, bus_a.imem_wdata, count_a, done_a, err_a} !==
        {1'b1, 8'd1, 32'h00853020, 9'd2, 2'b11}) begin
      n_bad++;
      $display("FAIL inv_second_add: got we=%b addr=%0h wdata=%08h count=%0d done=%b err=%b want 1/1/00853020/2/1/1",
               bus_a.imem_we, bus_a.imem_addr, bus_a.imem_wdata, count_a, done_a, err_a);
    end
    tick();
    n_cmp++;
    if (err_a !== 1'b1) begin
      n_bad++;
      $display("FAIL inv_err_sticky: got err=%b want 1", err_a);
    end
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n_cmp++;
    if (err_a !== 1'b0) begin
      n_bad++;
      $display("FAIL inv_err_clear: got err=%b want 0", err_a);
    end
    drive_a(1'b1, 4'd15, 5'd0, 5'd0, 5'd0, 26'd0, 1'b1);
    tick();
    drive_a(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b0);
    n_cmp++;
    if ({done_a, bus_a.imem_we, err_a, count_a} !== {3'b101, 9'd0}) begin
      n_bad++;
      $display("FAIL inv_last: got done=%b we=%b err=%b count=%0d want 1/0/1/0",
               done_a, bus_a.imem_we, err_a, count_a);
    end
  endtask

  task automatic test_encodings;
    logic [3:0]  ops [10];
    logic [4:0]  rss [10];
    logic [4:0]  rts [10];
    logic [4:0]  rds [10];
    logic [25:0] imms[10];
    logic [31:0] exps[10];
    ops[0] = 4'd2;  rss[0] = 5'd1;  rts[0] = 5'd2;  rds[0] = 5'd3;  imms[0] = 26'd0;        exps[0] = 32'h00221824;
    ops[1] = 4'd3;  rss[1] = 5'd1;  rts[1] = 5'd2;  rds[1] = 5'd3;  imms[1] = 26'd0;        exps[1] = 32'h00221825;
    ops[2] = 4'd4;  rss[2] = 5'd1;  rts[2] = 5'd2;  rds[2] = 5'd3;  imms[2] = 26'd0;        exps[2] = 32'h00221826;
    ops[3] = 4'd5;  rss[3] = 5'd1;  rts[3] = 5'd2;  rds[3] = 5'd3;  imms[3] = 26'd0;        exps[3] = 32'h00221827;
    ops[4] = 4'd6;  rss[4] = 5'd1;  rts[4] = 5'd2;  rds[4] = 5'd3;  imms[4] = 26'd0;        exps[4] = 32'h00221818;
    ops[5] = 4'd8;  rss[5] = 5'd29; rts[5] = 5'd31; rds[5] = 5'd0;  imms[5] = 26'h0001234;  exps[5] = 32'hAFBF1234;
    ops[6] = 4'd9;  rss[6] = 5'd3;  rts[6] = 5'd4;  rds[6] = 5'd9;  imms[6] = 26'h0008000;  exps[6] = 32'h20648000;
    ops[7] = 4'd11; rss[7] = 5'd5;  rts[7] = 5'd6;  rds[7] = 5'd0;  imms[7] = 26'h3FF0010;  exps[7] = 32'h14A60010;
    ops[8] = 4'd12; rss[8] = 5'd31; rts[8] = 5'd31; rds[8] = 5'd31; imms[8] = 26'h3FFFFFF;  exps[8] = 32'h0BFFFFFF;
    ops[9] = 4'd0;  rss[9] = 5'd31; rts[9] = 5'd0;  rds[9] = 5'd31; imms[9] = 26'h3FFFFFF;  exps[9] = 32'h03E0F820;
    begin_session_a();
    for (int i = 0; i < 10; i++) begin
      drive_a(1'b1, ops[i], rss[i], rts[i], rds[i], imms[i], 1'b0);
      tick();
      n_cmp++;
      if ({bus_a.imem_we, bus_a.imem_addr, bus_a.imem_wdata} !== {1'b1, 8'(i), exps[i]}) begin
        n_bad++;
        $display("FAIL enc_op%0d: got we=%b addr=%0h wdata=%08h want 1/%0h/%08h",
                 ops[i], bus_a.imem_we, bus_a.imem_addr, bus_a.imem_wdata, i, exps[i]);
      end
    end
    drive_a(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b0);
  endtask

  task automatic test_full;
    int nw = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    bus_b.in_valid = 1'b1;
    bus_b.in_op    = 4'd0;
    bus_b.in_rs    = 5'd1;
    bus_b.in_rt    = 5'd2;
    bus_b.in_rd    = 5'd3;
    bus_b.in_imm   = 26'd0;
    bus_b.in_last  = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus_b.imem_we === 1'b1) begin
        n_cmp++;
        if (bus_b.imem_addr !== 8'(nw)) begin
          n_bad++;
          $display("FAIL full_addr: got %0h want %0h", bus_b.imem_addr, nw);
        end
        nw++;
      end
    end
    n_cmp++;
    if (nw !== 4) begin
      n_bad++;
      $display("FAIL full_writes: got %0d want 4", nw);
    end
    n_cmp++;
    if ({bus_b.in_ready, done_b, busy_b, count_b} !== {3'b010, 9'd4}) begin
      n_bad++;
      $display("FAIL full_state: got ready=%b done=%b busy=%b count=%0d want 0/1/0/4",
               bus_b.in_ready, done_b, busy_b, count_b);
    end
    bus_b.in_valid = 1'b0;
  endtask

  task automatic test_reset_mid;
    begin_session_a();
    drive_a(1'b1, 4'd0, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0);
    tick();
    drive_a(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if ({bus_a.imem_we, bus_a.in_ready, busy_a, done_a, err_a} !== 5'b0) begin
      n_bad++;
      $display("FAIL rstmid_flags: got we/ready/busy/done/err=%b want 00000",
               {bus_a.imem_we, bus_a.in_ready, busy_a, done_a, err_a});
    end
    n_cmp++;
    if ({bus_a.imem_addr, bus_a.imem_wdata, count_a} !== 49'd0) begin
      n_bad++;
      $display("FAIL rstmid_regs: got addr=%0h wdata=%08h count=%0d want 0/0/0",
               bus_a.imem_addr, bus_a.imem_wdata, count_a);
    end
    drive_a(1'b1, 4'd0, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0);
    tick();
    drive_a(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b0);
    n_cmp++;
    if ({bus_a.imem_we, count_a} !== 10'd0) begin
      n_bad++;
      $display("FAIL rstmid_idle: got we=%b count=%0d want 0/0", bus_a.imem_we, count_a);
    end
  endtask

  initial begin
    drive_a(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b0);
    bus_b.in_valid = 1'b0;
    bus_b.in_op    = 4'd0;
    bus_b.in_rs    = 5'd0;
    bus_b.in_rt    = 5'd0;
    bus_b.in_rd    = 5'd0;
    bus_b.in_imm   = 26'd0;
    bus_b.in_last  = 1'b0;
    test_reset();
    test_add();
    test_back_to_back();
    test_last();
    test_invalid();
    test_encodings();
    test_full();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
